mix_columns_engine: RTL and testbench

Multi-cycle, handshaked AES MixColumns / InvMixColumns unit for the round datapath, between ShiftRows and AddRoundKey. It processes one 128-bit state per transaction, transforming COLS_PER_CYCLE columns per clock, so the area/latency trade-off is set at build time. Inverse mode can be selected per block, and a skid-free output hold supports downstream backpressure.

---
 rtl/mix_columns_engine.sv | 151 +++++++++++++++
 tb/tb_mix_columns_engine.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_engine.sv
// AES MixColumns / InvMixColumns engine: one 128-bit state per transaction, COLS_PER_CYCLE columns per clock.
// Latency: result valid 4/COLS_PER_CYCLE cycles after accept; one block per 4/COLS_PER_CYCLE+1 cycles sustained.
// Backpressure: result held in DONE until out_ready; a new block is accepted in the same cycle the result leaves.
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_ready/in_data/in_inverse   : upstream block handshake, mode sampled with the data
//   out_valid/out_ready/out_data/out_inverse: registered result handshake, mode echoed with the result
//   busy                                   : engine is not idle
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_inverse,
  output logic         busy
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  // Column index of the final group; col_idx only ever takes multiples of COLS_PER_CYCLE.
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t       state;
  logic [1:0]   col_idx;
  logic [127:0] work;
  logic [127:0] result;
  logic [127:0] next_result;
  logic         mode_inv;
  int           col_sel;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // One column through the forward or inverse matrix; multiples come from chained xtime.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a  [4];
    logic [7:0] x2 [4];
    logic [7:0] x3 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [31:0] o;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x3[i] = x2[i] ^ a[i];
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
    if (inv) begin
      o[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      o[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      o[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      o[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end else begin
      o[31:24] = x2[0] ^ x3[1] ^ a[2]  ^ a[3];
      o[23:16] = a[0]  ^ x2[1] ^ x3[2] ^ a[3];
      o[15:8]  = a[0]  ^ a[1]  ^ x2[2] ^ x3[3];
      o[7:0]   = x3[0] ^ a[1]  ^ a[2]  ^ x2[3];
    end
    return o;
  endfunction

  // Transform the current column group; other columns of the result keep their value.
  always_comb begin
    next_result = result;
    col_sel     = 0;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      col_sel = int'(col_idx) + g;
      next_result[127-32*col_sel -: 32] = mix_col(work[127-32*col_sel -: 32], mode_inv);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      col_idx     <= '0;
      work        <= '0;
      result      <= '0;
      mode_inv    <= 1'b0;
      out_valid   <= 1'b0;
      out_inverse <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= in_data;
            mode_inv <= INV_EN && in_inverse;
            col_idx  <= '0;
            state    <= PROC;
          end
        end
        PROC: begin
          result <= next_result;
          if (col_idx == LAST_COL) begin
            col_idx     <= '0;
            out_valid   <= 1'b1;
            out_inverse <= mode_inv;
            state       <= DONE;
          end else begin
            col_idx <= col_idx + COL_STEP;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              // Result leaves and the next block enters on the same edge.
              work     <= in_data;
              mode_inv <= INV_EN && in_inverse;
              col_idx  <= '0;
              state    <= PROC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign busy     = (state != IDLE);
  assign out_data = result;

endmodule

// File: tb/tb_mix_columns_engine.sv
// Self-checking bench for mix_columns_engine: four instances (CPC 1, 2, 4 with inverse; CPC 1 forward-only).
// Latency: n/a (bench).
// Backpressure: out_ready driven per test to exercise hold and same-cycle hand-over.
module tb_mix_columns_engine;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid    [N];
  logic         in_ready    [N];
  logic [127:0] in_data     [N];
  logic         in_inverse  [N];
  logic         out_valid   [N];
  logic         out_ready   [N];
  logic [127:0] out_data    [N];
  logic         out_inverse [N];
  logic         busy        [N];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_dut
      mix_columns_engine #(
        .COLS_PER_CYCLE((gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 4 : 1),
        .INV_EN(gi != 3)
      ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid[gi]),
        .in_ready   (in_ready[gi]),
        .in_data    (in_data[gi]),
        .in_inverse (in_inverse[gi]),
        .out_valid  (out_valid[gi]),
        .out_ready  (out_ready[gi]),
        .out_data   (out_data[gi]),
        .out_inverse(out_inverse[gi]),
        .busy       (busy[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: textbook GF(2^8) multiply and matrix-vector product per column.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    int p = 0;
    int x = int'(a);
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
    end
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit inv);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(base[(j - row + 4) % 4], s[127-8*(4*c+j) -: 8]);
        r[127-8*(4*c+row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int cpc(input int d);
    return (d == 1) ? 2 : (d == 2) ? 4 : 1;
  endfunction

  // Present one block, wait for its result, consume it. Flips in_inverse after accept.
  task automatic run_block(input int d, input logic [127:0] data, input bit inv,
                           output logic [127:0] res, output logic res_inv, output int lat);
    bit acc;
    acc = 1'b0;
    in_data[d]    = data;
    in_inverse[d] = inv;
    in_valid[d]   = 1'b1;
    for (int n = 0; n < 50 && !acc; n++) begin
      acc = in_ready[d];
      @(posedge clk); #1;
    end
    check("accept", 128'(acc), 128'(1));
    in_valid[d]   = 1'b0;
    in_inverse[d] = ~inv;
    lat = 0;
    while (!out_valid[d] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    res          = out_data[d];
    res_inv      = out_inverse[d];
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] res, res2, held, x, a_blk, c_blk;
    logic         rinv;
    int           lat;
    logic [127:0] blk  [8];
    bit           binv [8];
    logic [127:0] gotd [8];
    logic         goti [8];
    int           gott [8];
    int           j, got, cyc;
    bit           acc;

    rst = 1'b0;
    for (int d = 0; d < N; d++) begin
      in_valid[d] = 1'b0; in_data[d] = '0; in_inverse[d] = 1'b0; out_ready[d] = 1'b0;
    end
    #12;
    for (int d = 0; d < N; d++) begin
      check("rst_out_valid",   128'(out_valid[d]),   128'(0));
      check("rst_out_data",    out_data[d],          128'(0));
      check("rst_out_inverse", 128'(out_inverse[d]), 128'(0));
      check("rst_busy",        128'(busy[d]),        128'(0));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < N; d++) check("post_rst_in_ready", 128'(in_ready[d]), 128'(1));

    // FIPS-197 vector, forward, CPC=1
    run_block(0, 128'hdb135345_f20a225c_01010101_2d26314c, 1'b0, res, rinv, lat);
    check("fips_fwd_data", res, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
    check("fips_fwd_lat", 128'(lat), 128'(4));
    check("fips_fwd_inv", 128'(rinv), 128'(0));

    // Per-byte reduction
    run_block(0, 128'hd4d4d4d5_c6c6c6c6_d4d4d4d5_c6c6c6c6, 1'b0, res, rinv, lat);
    check("byte_reduce", res, 128'hd5d5d7d6_c6c6c6c6_d5d5d7d6_c6c6c6c6);
    for (int r = 0; r < 4; r++) begin
      x = rand128();
      for (int c = 0; c < 4; c++) x[127-8*(4*c+r) -: 8] = 8'h80;
      run_block(0, x, 1'b0, res, rinv, lat);
      check("row80", res, ref_mix(x, 1'b0));
    end

    // Inverse vector, CPC=4
    run_block(2, 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, 1'b1, res, rinv, lat);
    check("fips_inv_data", res, 128'hdb135345_f20a225c_01010101_2d26314c);
    check("fips_inv_lat", 128'(lat), 128'(1));
    check("fips_inv_flag", 128'(rinv), 128'(1));

    // Forward-only instance ignores in_inverse
    x = rand128();
    run_block(3, x, 1'b1, res, rinv, lat);
    check("fwd_only_data", res, ref_mix(x, 1'b0));
    check("fwd_only_flag", 128'(rinv), 128'(0));

    // Random round trips on each CPC
    for (int d = 0; d < 3; d++) begin
      for (int k = 0; k < 1000; k++) begin
        x = rand128();
        run_block(d, x, 1'b0, res, rinv, lat);
        check("rt_fwd", res, ref_mix(x, 1'b0));
        check("rt_lat", 128'(lat), 128'(4 / cpc(d)));
        run_block(d, res, 1'b1, res2, rinv, lat);
        check("rt_inv", res2, x);
        check("rt_inv_flag", 128'(rinv), 128'(1));
      end
    end

    // Backpressure on CPC=1
    a_blk = rand128();
    c_blk = rand128();
    in_data[0] = a_blk; in_inverse[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 0;
    while (!out_valid[0] && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bp_lat", 128'(lat), 128'(4));
    held = out_data[0];
    check("bp_data", held, ref_mix(a_blk, 1'b0));
    for (int k = 0; k < 10; k++) begin
      in_valid[0] = (k == 5);
      in_data[0]  = rand128();
      #1;
      check("bp_in_ready", 128'(in_ready[0]), 128'(0));
      @(posedge clk); #1;
      check("bp_hold_data", out_data[0], held);
      check("bp_hold_valid", 128'(out_valid[0]), 128'(1));
    end
    in_data[0] = c_blk; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    #1;
    check("bp_release_ready", 128'(in_ready[0]), 128'(1));
    @(posedge clk); #1;
    in_valid[0] = 1'b0; out_ready[0] = 1'b0;
    check("bp_next_busy", 128'(busy[0]), 128'(1));
    check("bp_next_valid_low", 128'(out_valid[0]), 128'(0));
    lat = 0;
    while (!out_valid[0] && lat < 50) begin @(posedge clk); #1; lat++; end
    check("bp_next_data", out_data[0], ref_mix(c_blk, 1'b0));
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    check("bp_idle_after", 128'(busy[0]), 128'(0));

    // Back-to-back on CPC=2
    for (int k = 0; k < 8; k++) begin blk[k] = rand128(); binv[k] = ($urandom_range(0, 1) == 1); end
    j = 0; got = 0; cyc = 0;
    in_data[1] = blk[0]; in_inverse[1] = binv[0]; in_valid[1] = 1'b1; out_ready[1] = 1'b1;
    while (got < 8 && cyc < 200) begin
      acc = in_ready[1] && in_valid[1];
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        j++;
        if (j < 8) begin in_data[1] = blk[j]; in_inverse[1] = binv[j]; end
        else in_valid[1] = 1'b0;
      end
      if (out_valid[1]) begin
        gotd[got] = out_data[1]; goti[got] = out_inverse[1]; gott[got] = cyc; got++;
      end
    end
    in_valid[1] = 1'b0; out_ready[1] = 1'b0;
    check("b2b_count", 128'(got), 128'(8));
    for (int k = 0; k < got; k++) begin
      check("b2b_data", gotd[k], ref_mix(blk[k], binv[k]));
      check("b2b_inv", 128'(goti[k]), 128'(binv[k]));
      if (k > 0) check("b2b_interval", 128'(gott[k] - gott[k-1]), 128'(3));
    end
    @(posedge clk); #1;

    // Reset mid-PROC on CPC=1
    x = rand128();
    in_data[0] = x; in_inverse[0] = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mid_valid", 128'(out_valid[0]), 128'(0));
    check("rst_mid_data", out_data[0], 128'(0));
    check("rst_mid_busy", 128'(busy[0]), 128'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    x = rand128();
    run_block(0, x, 1'b0, res, rinv, lat);
    check("post_rst_data", res, ref_mix(x, 1'b0));
    check("post_rst_lat", 128'(lat), 128'(4));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
